// File: rtl/sel_max_stream.sv
// Streaming row-maximum / argmax unit: one LANES-wide beat per cycle goes
// through a registered comparator tree, and the per-beat winners are merged
// into a running per-row maximum. One result is emitted per I_LAST row.

// Single compare node: b replaces a only when strictly greater, so ties keep a.
module sel_max_node #(
  parameter int D_W = 16,
  parameter int IW  = 4
) (
  input  logic [D_W-1:0] a_val_i,
  input  logic [IW-1:0]  a_idx_i,
  input  logic [D_W-1:0] b_val_i,
  input  logic [IW-1:0]  b_idx_i,
  input  logic           sgn_i,
  output logic [D_W-1:0] val_o,
  output logic [IW-1:0]  idx_o
);
  logic b_gt;

  // Mode-dependent strict greater-than; the winner is muxed through.
  always_comb begin
    b_gt  = sgn_i ? ($signed(b_val_i) > $signed(a_val_i)) : (b_val_i > a_val_i);
    val_o = b_gt ? b_val_i : a_val_i;
    idx_o = b_gt ? b_idx_i : a_idx_i;
  end
endmodule

module sel_max_stream #(
  parameter int D_W   = 16,
  parameter int LANES = 16,
  parameter int CNT_W = 8
) (
  input  logic                              I_CLK,
  input  logic                              I_RST,
  input  logic                              I_VLD,
  output logic                              O_RDY,
  input  logic [LANES-1:0][D_W-1:0]         I_DATA,
  input  logic                              I_LAST,
  input  logic                              I_SIGNED,
  output logic                              O_VLD,
  input  logic                              I_RDY,
  output logic [D_W-1:0]                    O_MAX,
  output logic [CNT_W+$clog2(LANES)-1:0]    O_IDX,
  output logic [CNT_W-1:0]                  O_CNT
);
  localparam int L     = $clog2(LANES);
  localparam int NODES = 2*LANES - 1;
  localparam int IW    = CNT_W + L;

  typedef enum logic {EMPTY, ACCUM} state_t;

  // The tree is a heap: node n has children 2n+1 / 2n+2, leaves hold the
  // registered input lanes in order (lower lanes on the left), node 0 is root.
  logic [NODES-1:0][D_W-1:0] val_q;
  logic [NODES-1:0][L-1:0]   idx_q;
  logic [LANES-2:0][D_W-1:0] win_val;
  logic [LANES-2:0][L-1:0]   win_idx;

  // Per-stage sideband: stage 0 = registered input, stage L = tree root.
  logic [L:0]            vld_pipe, sgn_pipe, last_pipe;
  logic [L:0][CNT_W-1:0] beat_pipe;
  logic [CNT_W-1:0]      beat_q;

  state_t         state_q, state_d;
  logic [D_W-1:0] acc_max_q, acc_max_d, mrg_val, new_val;
  logic [IW-1:0]  acc_idx_q, acc_idx_d, mrg_idx, new_idx, t_idx;
  logic           stall, fire, load;
  logic           o_vld_q;
  logic [D_W-1:0] o_max_q;
  logic [IW-1:0]  o_idx_q;
  logic [CNT_W-1:0] o_cnt_q;

  assign stall = o_vld_q && !I_RDY;
  assign O_RDY = !stall;
  assign O_VLD = o_vld_q;
  assign O_MAX = o_max_q;
  assign O_IDX = o_idx_q;
  assign O_CNT = o_cnt_q;

  // Comparator array; each node takes the mode flag of the stage feeding it.
  for (genvar n = 0; n < LANES-1; n++) begin : g_node
    localparam int DEP = $clog2(n+2) - 1;
    sel_max_node #(.D_W(D_W), .IW(L)) u_node (
      .a_val_i (val_q[2*n+1]), .a_idx_i (idx_q[2*n+1]),
      .b_val_i (val_q[2*n+2]), .b_idx_i (idx_q[2*n+2]),
      .sgn_i   (sgn_pipe[L-1-DEP]),
      .val_o   (win_val[n]),   .idx_o   (win_idx[n])
    );
  end

  // Valid shift register and beat counter; everything freezes on stall.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      vld_pipe <= '0;
      beat_q   <= '0;
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[L-1:0], I_VLD};
      if (I_VLD) beat_q <= I_LAST ? '0 : beat_q + 1'b1;
    end
  end

  // Tree datapath and sideband; payload is qualified by vld_pipe, so no reset.
  always_ff @(posedge I_CLK) begin
    if (!stall) begin
      sgn_pipe  <= {sgn_pipe[L-1:0], I_SIGNED};
      last_pipe <= {last_pipe[L-1:0], I_LAST};
      beat_pipe <= {beat_pipe[L-1:0], beat_q};
      for (int i = 0; i < LANES; i++) begin
        val_q[LANES-1+i] <= I_DATA[i];
        idx_q[LANES-1+i] <= L'(i);
      end
      for (int n = 0; n < LANES-1; n++) begin
        val_q[n] <= win_val[n];
        idx_q[n] <= win_idx[n];
      end
    end
  end

  // Row merge: the earlier accumulated index wins ties.
  assign t_idx = {beat_pipe[L], idx_q[0]};
  assign fire  = vld_pipe[L] && !stall;

  sel_max_node #(.D_W(D_W), .IW(IW)) u_merge (
    .a_val_i (acc_max_q), .a_idx_i (acc_idx_q),
    .b_val_i (val_q[0]),  .b_idx_i (t_idx),
    .sgn_i   (sgn_pipe[L]),
    .val_o   (mrg_val),   .idx_o   (mrg_idx)
  );

  // Accumulator next state: load first beat as-is, merge later beats, flush on last.
  always_comb begin
    state_d   = state_q;
    acc_max_d = acc_max_q;
    acc_idx_d = acc_idx_q;
    load      = 1'b0;
    new_val   = (state_q == EMPTY) ? val_q[0] : mrg_val;
    new_idx   = (state_q == EMPTY) ? t_idx    : mrg_idx;
    if (fire) begin
      if (last_pipe[L]) begin
        load    = 1'b1;
        state_d = EMPTY;
      end else begin
        state_d   = ACCUM;
        acc_max_d = new_val;
        acc_idx_d = new_idx;
      end
    end
  end

  // Accumulator state register.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q   <= EMPTY;
      acc_max_q <= '0;
      acc_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_max_q <= acc_max_d;
      acc_idx_q <= acc_idx_d;
    end
  end

  // Result register: a new load overrides the consume-clear in the same cycle.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      o_vld_q <= 1'b0;
      o_max_q <= '0;
      o_idx_q <= '0;
      o_cnt_q <= '0;
    end else if (load) begin
      o_vld_q <= 1'b1;
      o_max_q <= new_val;
      o_idx_q <= new_idx;
      o_cnt_q <= beat_pipe[L];
    end else if (o_vld_q && I_RDY) begin
      o_vld_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sel_max_stream.sv
module tb_sel_max_stream;
  localparam int D_W = 16, LANES = 16, CNT_W = 8, L = 4;

  typedef logic [LANES-1:0][D_W-1:0] beat_t;
  typedef struct packed {
    logic [D_W-1:0]     mx;
    logic [CNT_W+L-1:0] idx;
    logic [CNT_W-1:0]   cnt;
  } res_t;

  logic clk, rst, vld, lst, sg, rdy;
  beat_t data;
  logic o_rdy, o_vld;
  logic [D_W-1:0] o_max;
  logic [CNT_W+L-1:0] o_idx;
  logic [CNT_W-1:0] o_cnt;

  res_t sb[$];
  int stamps[$];
  int checks = 0, errors = 0, cyc = 0;

  sel_max_stream #(.D_W(D_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .I_CLK(clk), .I_RST(rst), .I_VLD(vld), .O_RDY(o_rdy), .I_DATA(data),
    .I_LAST(lst), .I_SIGNED(sg), .O_VLD(o_vld), .I_RDY(rdy),
    .O_MAX(o_max), .O_IDX(o_idx), .O_CNT(o_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [D_W-1:0] mx, input int idx, input int cnt);
    res_t e;
    e.mx = mx; e.idx = (CNT_W+L)'(idx); e.cnt = CNT_W'(cnt);
    sb.push_back(e);
  endtask

  // Scoreboard monitor: compares every result on the cycle it is consumed.
  always @(negedge clk) begin : mon
    res_t e;
    if (!rst && o_vld && rdy) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: got max %0h idx %0h with none expected", o_max, o_idx);
      end else begin
        e = sb.pop_front();
        chk("res_max", o_max, e.mx);
        chk("res_idx", o_idx, e.idx);
        chk("res_cnt", o_cnt, e.cnt);
        stamps.push_back(cyc);
      end
    end
  end

  // Present one beat and hold it until accepted; reports whether it waited.
  task automatic send(input beat_t d, input logic last, input logic sgn, output int waited);
    int n;
    vld = 1'b1; data = d; lst = last; sg = sgn; waited = 0; n = 0;
    @(negedge clk);
    while (!o_rdy && n < 100) begin
      waited = 1; n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL send_timeout: got O_RDY 0 for 100 cycles expected 1");
    end
    @(posedge clk); #1;
    vld = 1'b0;
  endtask

  task automatic wait_vld();
    int n;
    n = 0;
    @(negedge clk);
    while (!o_vld && n < 50) begin n++; @(negedge clk); end
    chk("wait_vld", o_vld, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || o_vld) && n < 60) begin n++; @(negedge clk); end
    chk("drain_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b0, b1, b2;
    int w;
    rst = 1'b1; vld = 1'b0; lst = 1'b0; sg = 1'b0; rdy = 1'b1; data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_vld", o_vld, 0);
    chk("rst_rdy", o_rdy, 1);
    chk("rst_max", o_max, 0);
    chk("rst_idx", o_idx, 0);
    chk("rst_cnt", o_cnt, 0);

    // Single signed beat, plus latency: O_VLD rises exactly L+1 edges later.
    for (int i = 0; i < LANES; i++) b0[i] = 16'(i - 8);
    b0[5] = 16'h7FFF;
    push(16'h7FFF, 5, 0);
    send(b0, 1'b1, 1'b1, w);
    repeat (L) @(posedge clk);
    #1 chk("lat_early", o_vld, 0);
    @(posedge clk);
    #1 chk("lat_vld", o_vld, 1);
    drain();

    // Same data compared signed, then unsigned.
    for (int i = 0; i < LANES; i++) b0[i] = 16'h0001;
    b0[3] = 16'h8000;
    push(16'h0001, 0, 0);
    send(b0, 1'b1, 1'b1, w);
    push(16'h8000, 3, 0);
    send(b0, 1'b1, 1'b0, w);
    drain();

    // Equal maxima in two beats: the earlier index is kept.
    for (int i = 0; i < LANES; i++) begin b0[i] = 16'h0010; b1[i] = 16'h0010; b2[i] = 16'h0010; end
    b1[2] = 16'h0020;
    b2[7] = 16'h0020;
    push(16'h0020, 18, 2);
    send(b0, 1'b0, 1'b0, w);
    send(b1, 1'b0, 1'b0, w);
    send(b2, 1'b1, 1'b0, w);
    drain();

    // Back-to-back 2-beat rows: never stalls, one result every 2 cycles.
    stamps.delete();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < LANES; i++) begin b0[i] = 16'(r + 1); b1[i] = 16'(r + 2); end
      if (r % 2 == 0) b0[r] = 16'(16'h0100 + r);
      else            b1[r] = 16'(16'h0100 + r);
      push(16'(16'h0100 + r), (r % 2) * LANES + r, 1);
      send(b0, 1'b0, 1'b0, w);
      chk("b2b_nowait0", w, 0);
      send(b1, 1'b1, 1'b0, w);
      chk("b2b_nowait1", w, 0);
    end
    drain();
    chk("b2b_count", stamps.size(), 4);
    for (int i = 1; i < stamps.size(); i++) chk("b2b_gap", stamps[i] - stamps[i-1], 2);

    // Backpressure: result A held 5 cycles while row B queues behind it.
    rdy = 1'b0;
    for (int i = 0; i < LANES; i++) b0[i] = 16'h0001;
    b0[9] = 16'h0AAA;
    push(16'h0AAA, 9, 0);
    send(b0, 1'b1, 1'b0, w);
    for (int i = 0; i < LANES; i++) begin b1[i] = 16'h0005; b2[i] = 16'h0004; end
    b1[15] = 16'h0300;
    b2[0]  = 16'h0300;
    fork
      begin
        push(16'h0300, 15, 1);
        send(b1, 1'b0, 1'b0, w);
        send(b2, 1'b1, 1'b0, w);
      end
      begin
        wait_vld();
        repeat (5) begin
          @(negedge clk);
          chk("bp_rdy", o_rdy, 0);
          chk("bp_vld", o_vld, 1);
          chk("bp_max", o_max, 16'h0AAA);
          chk("bp_idx", o_idx, 9);
        end
        @(posedge clk); #1 rdy = 1'b1;
      end
    join
    drain();

    // Reset mid-row: partial row and in-flight beats are discarded.
    for (int i = 0; i < LANES; i++) begin b0[i] = 16'h0010; b1[i] = 16'h0010; end
    b0[4] = 16'h7000;
    send(b0, 1'b0, 1'b0, w);
    send(b1, 1'b0, 1'b0, w);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_vld", o_vld, 0);
    chk("midrst_rdy", o_rdy, 1);
    for (int i = 0; i < LANES; i++) begin b0[i] = 16'h0010; b1[i] = 16'h0020; end
    b0[6] = 16'h0050;
    push(16'h0050, 6, 1);
    send(b0, 1'b0, 1'b0, w);
    send(b1, 1'b1, 1'b0, w);
    drain();
    repeat (L + 3) @(posedge clk);
    #1 chk("idle_vld", o_vld, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
